// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin arbiter sharing one single-port data RAM between two requesters,
// with a one-cycle registered load response per port.
module mem_arbiter #(
  parameter int   DATA_WIDTH = 32,
  parameter logic RESET_PRIO = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req0,
  input  logic                  req1,
  input  logic                  we0,
  input  logic                  we1,
  input  logic [DATA_WIDTH-1:0] addr0,
  input  logic [DATA_WIDTH-1:0] addr1,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic [DATA_WIDTH-1:0] wdata1,
  input  logic [2:0]            func3_0,
  input  logic [2:0]            func3_1,
  output logic                  gnt0,
  output logic                  gnt1,
  output logic                  rvalid0,
  output logic                  rvalid1,
  output logic [DATA_WIDTH-1:0] rdata0,
  output logic [DATA_WIDTH-1:0] rdata1,
  output logic [DATA_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [2:0]            mem_func3,
  output logic                  mem_we,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);
  typedef enum logic {IDLE, RESP_LOAD} resp_t;
  resp_t st0, st1, st0_n, st1_n;
  logic prio, prio_n;
  always_comb begin
    gnt0      = !rst && req0 && (!req1 || !prio);
    gnt1      = !rst && req1 && (!req0 || prio);
    mem_we    = gnt0 ? we0 : gnt1 ? we1 : 1'b0;
    mem_addr  = gnt0 ? addr0 : gnt1 ? addr1 : '0;
    mem_wdata = gnt0 ? wdata0 : gnt1 ? wdata1 : '0;
    mem_func3 = gnt0 ? func3_0 : gnt1 ? func3_1 : 3'd0;
    prio_n    = gnt0 ? 1'b1 : gnt1 ? 1'b0 : prio;
    st0_n     = (gnt0 && !we0) ? RESP_LOAD : IDLE;
    st1_n     = (gnt1 && !we1) ? RESP_LOAD : IDLE;
  end
  // a response pending when reset arrives must not be seen
  assign rvalid0 = !rst && st0 == RESP_LOAD;
  assign rvalid1 = !rst && st1 == RESP_LOAD;
  always_ff @(posedge clk) begin
    if (rst) begin
      prio   <= RESET_PRIO;
      st0    <= IDLE;
      st1    <= IDLE;
      rdata0 <= '0;
      rdata1 <= '0;
    end else begin
      prio <= prio_n;
      st0  <= st0_n;
      st1  <= st1_n;
      if (gnt0 && !we0) rdata0 <= mem_rdata;
      if (gnt1 && !we1) rdata1 <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scoreboard bench for mem_arbiter with a behavioural RAM and arbitration model.
module tb_mem_arbiter;
  localparam int   DW = 32;
  localparam logic RP = 1'b0;
  logic clk = 1'b0;
  logic rst;
  logic req0, req1, we0, we1;
  logic [DW-1:0] addr0, addr1, wdata0, wdata1;
  logic [2:0] func3_0, func3_1;
  logic gnt0, gnt1, rvalid0, rvalid1, mem_we;
  logic [DW-1:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;
  logic [2:0] mem_func3;
  always #5 clk = ~clk;
  mem_arbiter #(.DATA_WIDTH(DW), .RESET_PRIO(RP)) dut (
    .clk(clk), .rst(rst), .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
    .func3_0(func3_0), .func3_1(func3_1), .gnt0(gnt0), .gnt1(gnt1),
    .rvalid0(rvalid0), .rvalid1(rvalid1), .rdata0(rdata0), .rdata1(rdata1),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_func3(mem_func3),
    .mem_we(mem_we), .mem_rdata(mem_rdata)
  );
  function automatic logic [31:0] init_word(int i);
    return (i == 4) ? 32'hDEADBEEF : {8'hA5, i[7:0], 16'h3C3C};
  endfunction
  logic [31:0] ram [64];
  bit ram_ready;
  always @(posedge clk) begin
    if (!ram_ready) begin
      for (int i = 0; i < 64; i++) ram[i] <= init_word(i);
      ram_ready <= 1'b1;
    end else if (mem_we) ram[mem_addr[7:2]] <= mem_wdata;
  end
  assign mem_rdata = ram[mem_addr[7:2]];
  int n_chk, n_fail;
  logic mprio;
  logic [31:0] exp_ram [64];
  logic [31:0] q0 [$];
  logic [31:0] q1 [$];
  logic [31:0] last0, last1;
  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic p0(logic r, logic w, logic [31:0] a, logic [31:0] d, logic [2:0] f);
    req0 = r; we0 = w; addr0 = a; wdata0 = d; func3_0 = f;
  endtask
  task automatic p1(logic r, logic w, logic [31:0] a, logic [31:0] d, logic [2:0] f);
    req1 = r; we1 = w; addr1 = a; wdata1 = d; func3_1 = f;
  endtask
  task automatic step();
    logic e0, e1;
    #1;
    if (q0.size() > 0) begin
      last0 = q0.pop_front();
      chk("rvalid0", 32'(rvalid0), 32'(!rst));
    end else chk("rvalid0", 32'(rvalid0), 32'd0);
    if (q1.size() > 0) begin
      last1 = q1.pop_front();
      chk("rvalid1", 32'(rvalid1), 32'(!rst));
    end else chk("rvalid1", 32'(rvalid1), 32'd0);
    chk("rdata0", rdata0, last0);
    chk("rdata1", rdata1, last1);
    e0 = !rst && req0 && (!req1 || !mprio);
    e1 = !rst && req1 && (!req0 || mprio);
    chk("gnt0", 32'(gnt0), 32'(e0));
    chk("gnt1", 32'(gnt1), 32'(e1));
    chk("gnt_onehot", 32'(gnt0 & gnt1), 32'd0);
    chk("mem_we", 32'(mem_we), 32'(e0 ? we0 : e1 ? we1 : 1'b0));
    chk("mem_addr", mem_addr, e0 ? addr0 : e1 ? addr1 : 32'd0);
    chk("mem_wdata", mem_wdata, e0 ? wdata0 : e1 ? wdata1 : 32'd0);
    chk("mem_func3", 32'(mem_func3), 32'(e0 ? func3_0 : e1 ? func3_1 : 3'd0));
    if (e0 && !we0) q0.push_back(exp_ram[addr0[7:2]]);
    if (e1 && !we1) q1.push_back(exp_ram[addr1[7:2]]);
    if (e0 && we0) exp_ram[addr0[7:2]] = wdata0;
    if (e1 && we1) exp_ram[addr1[7:2]] = wdata1;
    @(posedge clk);
    if (rst) begin
      mprio = RP;
      last0 = '0;
      last1 = '0;
    end else if (e0) mprio = 1'b1;
    else if (e1) mprio = 1'b0;
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    n_chk = 0; n_fail = 0; mprio = RP; last0 = '0; last1 = '0;
    for (int i = 0; i < 64; i++) exp_ram[i] = init_word(i);
    rst = 1'b1;
    p0(1, 1, 32'h40, 32'hCAFE0000, 3'd2);
    p1(1, 1, 32'h44, 32'hBEEF0000, 3'd2);
    @(posedge clk); #1;
    repeat (3) step();
    rst = 1'b0;
    p0(1, 0, 32'h10, 32'h0, 3'd2); p1(0, 0, 32'h0, 32'h0, 3'd0);
    step();
    p0(0, 0, 32'h0, 32'h0, 3'd0);
    step();
    chk("load_0x10", rdata0, 32'hDEADBEEF);
    rst = 1'b1; step(); rst = 1'b0;
    p0(1, 0, 32'h00, 32'h0, 3'd2); p1(1, 0, 32'h04, 32'h0, 3'd4);
    repeat (4) step();
    p0(0, 0, 32'h0, 32'h0, 3'd0); p1(0, 0, 32'h0, 32'h0, 3'd0);
    step();
    p1(1, 1, 32'h20, 32'h12345678, 3'd2);
    step();
    p1(0, 0, 32'h0, 32'h0, 3'd0);
    step();
    p0(1, 0, 32'h20, 32'h0, 3'd2);
    step();
    p0(0, 0, 32'h0, 32'h0, 3'd0);
    step();
    chk("store_readback", rdata0, 32'h12345678);
    p0(1, 0, 32'h0, 32'h0, 3'd2); step();
    p0(1, 0, 32'h4, 32'h0, 3'd1); step();
    p0(1, 0, 32'h8, 32'h0, 3'd5); step();
    p0(0, 0, 32'h0, 32'h0, 3'd0); step();
    p0(1, 0, 32'h30, 32'h0, 3'd2); p1(1, 1, 32'h34, 32'h55AA55AA, 3'd1);
    step();
    p0(0, 0, 32'h0, 32'h0, 3'd0); p1(0, 0, 32'h0, 32'h0, 3'd0);
    step();
    p1(1, 0, 32'h34, 32'h0, 3'd2);
    step();
    p1(0, 0, 32'h0, 32'h0, 3'd0);
    rst = 1'b1; step(); rst = 1'b0;
    p0(1, 0, 32'h8, 32'h0, 3'd2); p1(1, 0, 32'hC, 32'h0, 3'd2);
    #1;
    chk("prio_after_rst", 32'(gnt0), 32'(!RP));
    step();
    p0(0, 0, 32'h0, 32'h0, 3'd0); p1(0, 0, 32'h0, 32'h0, 3'd0);
    step(); step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter DATA_WIDTH, default 32, SHALL set the width of data and address buses.
REQ-002 Parameter RESET_PRIO, default 0, SHALL set which port holds priority after reset.
REQ-003 The block SHALL use one clock; reset is synchronous and active-high.
REQ-004 Port `clk`, input, 1 bit, SHALL be the clock; all state updates on its rising edge.
REQ-005 Port `rst`, input, 1 bit, SHALL be the synchronous active-high reset.
REQ-006 Ports `req0`/`req1`, input, 1 bit each, SHALL be the access requests from port 0 (CPU data) and port 1 (loader/debug).
REQ-007 Ports `we0`/`we1`, input, 1 bit each, SHALL be the write enables (1 = store, 0 = load).
REQ-008 Ports `addr0`/`addr1`, input, DATA_WIDTH each, SHALL be the byte addresses.
REQ-009 Ports `wdata0`/`wdata1`, input, DATA_WIDTH each, SHALL be the store data.
REQ-010 Ports `func3_0`/`func3_1`, input, 3 bits each, SHALL be the access width/sign codes, passed through unchanged.
REQ-011 Ports `gnt0`/`gnt1`, output, 1 bit each, SHALL mean that port's access is issued to memory this cycle.
REQ-012 Ports `rvalid0`/`rvalid1`, output, 1 bit each, SHALL mark valid load data on `rdata0`/`rdata1`.
REQ-013 Ports `rdata0`/`rdata1`, output, DATA_WIDTH each, SHALL carry the load data.
REQ-014 Ports `mem_addr`, `mem_wdata` (DATA_WIDTH), `mem_func3` (3 bits) and `mem_we` (1 bit), all outputs, SHALL drive the single-port data RAM.
REQ-015 Port `mem_rdata`, input, DATA_WIDTH, SHALL be the RAM's combinational read data for `mem_addr`.

Function
REQ-016 Arbitration SHALL be combinational from `req0`, `req1` and the registered priority bit `prio`; at most one of `gnt0`/`gnt1` SHALL be high in any cycle.
REQ-017 If exactly one port requests, that port SHALL be granted in the same cycle.
REQ-018 If both ports request, the port equal to `prio` SHALL be granted.
REQ-019 After every grant, `prio` SHALL move to the non-granted port (round-robin); with no grant, `prio` SHALL hold.
REQ-020 During a grant cycle, the `mem_*` outputs SHALL be driven from the granted port's address, write data, func3 and write enable.
REQ-021 With no grant, `mem_we` SHALL be 0; `mem_addr`, `mem_wdata` and `mem_func3` SHALL be 0.
REQ-022 A requester SHALL hold its req/we/addr/wdata/func3 stable until it sees its gnt; the arbiter SHALL NOT queue requests.
REQ-023 A granted load SHALL register `mem_rdata` into the granted port's `rdata` at the end of the grant cycle.
REQ-024 The granted port's `rvalid` SHALL assert for exactly one cycle, the cycle after the grant (latency 1).
REQ-025 A granted store SHALL produce no `rvalid`; its write commits at the grant-cycle edge.
REQ-026 `rdata` SHALL hold its last value when `rvalid` is low.
REQ-027 Back-to-back grants SHALL be allowed, so one access completes per cycle.
REQ-028 When a port is granted on consecutive cycles, its `rvalid` pipeline SHALL reflect each load independently.
REQ-029 The response pipeline SHALL be a per-port registered state of {IDLE, RESP_LOAD}, set to RESP_LOAD by a load grant and otherwise set to IDLE.
REQ-030 A request deasserted before its grant SHALL be dropped with no side effects.

Reset
REQ-031 While `rst` is high at a clock edge: `prio` ← RESET_PRIO; both response states ← IDLE; `rvalid0`/`rvalid1` ← 0; `rdata0`/`rdata1` ← 0.
REQ-032 During any cycle in which `rst` is high, `gnt0`, `gnt1` and `mem_we` SHALL be forced to 0, so no write occurs.
REQ-033 A load granted in the cycle before reset asserts SHALL NOT produce an `rvalid` after reset.

Verification
REQ-034 Reset, then `req0`=1 load, addr 0x10, RAM word 0xDEADBEEF -> `gnt0`=1 same cycle; next cycle `rvalid0`=1 and `rdata0`=0xDEADBEEF; `rvalid1`=0.
REQ-035 Both requesting continuously after reset (RESET_PRIO=0) -> grants alternate 0,1,0,1 across four cycles, and `gnt0`&`gnt1` is never 1.
REQ-036 `req1` store, addr 0x20, wdata 0x12345678 -> `mem_we`=1 and `mem_addr`=0x20 in the grant cycle, no `rvalid1`; a later port-0 load of 0x20 returns 0x12345678.
REQ-037 Port 0 issues loads on three consecutive cycles to 0x0, 0x4, 0x8 -> `rvalid0` high for three consecutive cycles with data in address order.
REQ-038 Assert `rst` in the cycle after a port-1 load grant -> `rvalid1` stays 0, `rdata1`=0, and `prio` returns to RESET_PRIO.
REQ-039 With `rst` held high while `req0`=`req1`=1 with store -> `gnt0`=`gnt1`=`mem_we`=0 every cycle.
